// File: rtl/tetris_step_sequencer.sv
// tetris_step_sequencer: per-tick game step FSM issuing one-clk command strobes.
// Optional: define LEVEL_SPEEDUP_EN to shorten the gravity period every 10 cleared lines.
module tetris_step_sequencer #(
   parameter int GRAVITY_TICKS = 6,
   parameter int MAX_DROP      = 24,
   parameter int MIN_GRAVITY   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       key_esc,
   input  logic       key_cw,
   input  logic       key_ccw,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_drop,
   input  logic       cw_ok,
   input  logic       ccw_ok,
   input  logic       left_ok,
   input  logic       right_ok,
   input  logic       down_ok,
   input  logic       row_full,
   input  logic       spawn_blocked,
   output logic       do_clear,
   output logic       do_spawn,
   output logic       do_cw,
   output logic       do_ccw,
   output logic       do_left,
   output logic       do_right,
   output logic       do_down,
   output logic       do_lock,
   output logic       do_elim,
   output logic       do_spawn_unused_n,
   output logic       score_hit,
   output logic [1:0] line_cnt,
   output logic       game_over,
   output logic [3:0] state_dbg
);
   typedef enum logic [3:0] {
      S_CLEAR, S_SPAWN, S_CW, S_CCW, S_LEFT, S_RIGHT, S_FALL,
      S_HDROP, S_LOCK, S_ELIM, S_SCORE, S_CHECK, S_OVER
   } state_t;
   // the period never drops below the speed-up floor, even for odd parameter sets
   localparam logic [7:0] BASE_PERIOD = 8'(GRAVITY_TICKS > MIN_GRAVITY ? GRAVITY_TICKS : MIN_GRAVITY);
   localparam logic [7:0] DROP_MAX    = 8'(MAX_DROP);
   state_t     state, state_nx;
   logic       esc_p, cw_p, ccw_p, left_p, right_p, drop_p;
   logic [7:0] grav_cnt, grav_nx, drop_cnt, drop_nx, period;
   logic [2:0] row_cnt, row_nx, row_m1;
   logic       step, expire, hd_go, el_go, at_over;
   logic       clear_d, spawn_d, cw_d, ccw_d, left_d, right_d, down_d, lock_d, elim_d, score_d, over_d;
   logic [1:0] line_d;
   assign step      = tick & ~esc_p;
   assign expire    = grav_cnt >= period - 8'd1;
   assign hd_go     = down_ok & (drop_cnt < DROP_MAX);
   assign el_go     = row_full & (row_cnt < 3'd4);
   assign at_over   = step & (state == S_OVER);
   assign row_m1    = row_cnt - 3'd1;
   assign state_dbg = state;
   assign do_spawn_unused_n = 1'b0;
   // state, step counters and pending key flags (a new key pulse beats a same-clk clear)
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_CLEAR;
         grav_cnt <= 8'd0;
         drop_cnt <= 8'd0;
         row_cnt  <= 3'd0;
         esc_p    <= 1'b0;
         cw_p     <= 1'b0;
         ccw_p    <= 1'b0;
         left_p   <= 1'b0;
         right_p  <= 1'b0;
         drop_p   <= 1'b0;
      end else begin
         state    <= state_nx;
         grav_cnt <= grav_nx;
         drop_cnt <= drop_nx;
         row_cnt  <= row_nx;
         esc_p    <= key_esc | (esc_p & ~tick);
         cw_p     <= key_cw | (cw_p & ~(at_over | (step & (state == S_CW))));
         ccw_p    <= key_ccw | (ccw_p & ~(at_over | (step & (state == S_CCW))));
         left_p   <= key_left | (left_p & ~(at_over | (step & (state == S_LEFT))));
         right_p  <= key_right | (right_p & ~(at_over | (step & (state == S_RIGHT))));
         drop_p   <= key_drop | (drop_p & ~(at_over | (step & (state == S_HDROP) & ~hd_go)));
      end
   end
   // next state and counter updates; a pending escape overrides whatever the state would do
   always_comb begin
      state_nx = state;
      grav_nx  = grav_cnt;
      drop_nx  = drop_cnt;
      row_nx   = row_cnt;
      if (tick && esc_p) state_nx = S_CLEAR;
      else if (tick) begin
         case (state)
            S_CLEAR: begin
               grav_nx  = 8'd0;
               state_nx = S_SPAWN;
            end
            S_SPAWN: state_nx = S_CW;
            S_CW:    state_nx = S_CCW;
            S_CCW:   state_nx = S_LEFT;
            S_LEFT:  state_nx = S_RIGHT;
            S_RIGHT: state_nx = S_FALL;
            S_FALL: begin
               if (drop_p) begin
                  drop_nx  = 8'd0;
                  state_nx = S_HDROP;
               end else if (expire) begin
                  grav_nx  = 8'd0;
                  state_nx = down_ok ? S_CW : S_LOCK;
               end else begin
                  grav_nx  = grav_cnt + 8'd1;
                  state_nx = S_CW;
               end
            end
            S_HDROP: begin
               if (hd_go) drop_nx = drop_cnt + 8'd1;
               else state_nx = S_LOCK;
            end
            S_LOCK: begin
               row_nx   = 3'd0;
               state_nx = S_ELIM;
            end
            S_ELIM: begin
               if (el_go) row_nx = row_cnt + 3'd1;
               else state_nx = S_SCORE;
            end
            S_SCORE: state_nx = S_CHECK;
            S_CHECK: state_nx = spawn_blocked ? S_OVER : S_SPAWN;
            S_OVER:  state_nx = S_OVER;
            default: state_nx = S_CLEAR;
         endcase
      end
   end
   // strobe selection for the current tick; registered below so each lasts one clk
   always_comb begin
      clear_d = 1'b0;
      spawn_d = 1'b0;
      cw_d    = 1'b0;
      ccw_d   = 1'b0;
      left_d  = 1'b0;
      right_d = 1'b0;
      down_d  = 1'b0;
      lock_d  = 1'b0;
      elim_d  = 1'b0;
      score_d = 1'b0;
      line_d  = 2'd0;
      over_d  = game_over;
      if (step) begin
         case (state)
            S_CLEAR: begin
               clear_d = 1'b1;
               over_d  = 1'b0;
            end
            S_SPAWN: spawn_d = 1'b1;
            S_CW:    cw_d    = cw_p & cw_ok;
            S_CCW:   ccw_d   = ccw_p & ccw_ok;
            S_LEFT:  left_d  = left_p & left_ok;
            S_RIGHT: right_d = right_p & right_ok;
            S_FALL:  down_d  = ~drop_p & expire & down_ok;
            S_HDROP: down_d  = hd_go;
            S_LOCK:  lock_d  = 1'b1;
            S_ELIM:  elim_d  = el_go;
            S_SCORE: begin
               score_d = row_cnt != 3'd0;
               line_d  = score_d ? row_m1[1:0] : 2'd0;
            end
            S_CHECK: over_d = game_over | spawn_blocked;
            default: ;
         endcase
      end
   end
   // output strobe and game-over registers
   always_ff @(posedge clk) begin
      if (rst) begin
         do_clear  <= 1'b0;
         do_spawn  <= 1'b0;
         do_cw     <= 1'b0;
         do_ccw    <= 1'b0;
         do_left   <= 1'b0;
         do_right  <= 1'b0;
         do_down   <= 1'b0;
         do_lock   <= 1'b0;
         do_elim   <= 1'b0;
         score_hit <= 1'b0;
         line_cnt  <= 2'd0;
         game_over <= 1'b0;
      end else begin
         do_clear  <= clear_d;
         do_spawn  <= spawn_d;
         do_cw     <= cw_d;
         do_ccw    <= ccw_d;
         do_left   <= left_d;
         do_right  <= right_d;
         do_down   <= down_d;
         do_lock   <= lock_d;
         do_elim   <= elim_d;
         score_hit <= score_d;
         line_cnt  <= line_d;
         game_over <= over_d;
      end
   end
`ifdef LEVEL_SPEEDUP_EN
   localparam logic [7:0] MIN_PERIOD = 8'(MIN_GRAVITY);
   logic [3:0] acc;
   logic [4:0] acc_sum;
   logic       level_up;
   assign acc_sum  = {1'b0, acc} + {2'b00, row_cnt};
   assign level_up = acc_sum >= 5'd10;
   // lines-cleared accumulator; every 10 lines shortens the gravity period down to the floor
   always_ff @(posedge clk) begin
      if (rst || (step && state == S_CLEAR)) begin
         acc    <= 4'd0;
         period <= BASE_PERIOD;
      end else if (step && state == S_SCORE) begin
         acc <= level_up ? 4'(acc_sum - 5'd10) : acc_sum[3:0];
         if (level_up && period > MIN_PERIOD) period <= period - 8'd1;
      end
   end
`else
   assign period = BASE_PERIOD;
`endif
endmodule

// File: tb/tb_tetris_step_sequencer.sv
// tb_tetris_step_sequencer: directed scenario tasks with hand-computed expectations.
module tb_tetris_step_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic key_esc = 1'b0, key_cw = 1'b0, key_ccw = 1'b0, key_left = 1'b0, key_right = 1'b0, key_drop = 1'b0;
   logic cw_ok = 1'b1, ccw_ok = 1'b1, left_ok = 1'b1, right_ok = 1'b1, down_ok = 1'b1;
   logic row_full = 1'b0, spawn_blocked = 1'b0;
   logic do_clear, do_spawn, do_cw, do_ccw, do_left, do_right, do_down, do_lock, do_elim, do_spawn_unused_n, score_hit;
   logic [1:0] line_cnt;
   logic game_over;
   logic [3:0] state_dbg;
   logic [9:0] strobes;
   int n_checks = 0, n_fail = 0;
   int n_any, n_cw, n_left, n_down, n_lock, n_elim;

   localparam logic [3:0] ST_CLEAR = 4'd0, ST_SPAWN = 4'd1, ST_CW = 4'd2, ST_RIGHT = 4'd5, ST_FALL = 4'd6,
                          ST_HDROP = 4'd7, ST_LOCK = 4'd8, ST_ELIM = 4'd9, ST_SCORE = 4'd10, ST_CHECK = 4'd11,
                          ST_OVER = 4'd12;

   tetris_step_sequencer dut (
      .clk(clk), .rst(rst), .tick(tick),
      .key_esc(key_esc), .key_cw(key_cw), .key_ccw(key_ccw), .key_left(key_left), .key_right(key_right),
      .key_drop(key_drop), .cw_ok(cw_ok), .ccw_ok(ccw_ok), .left_ok(left_ok), .right_ok(right_ok),
      .down_ok(down_ok), .row_full(row_full), .spawn_blocked(spawn_blocked),
      .do_clear(do_clear), .do_spawn(do_spawn), .do_cw(do_cw), .do_ccw(do_ccw), .do_left(do_left),
      .do_right(do_right), .do_down(do_down), .do_lock(do_lock), .do_elim(do_elim),
      .do_spawn_unused_n(do_spawn_unused_n), .score_hit(score_hit),
      .line_cnt(line_cnt), .game_over(game_over), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;
   assign strobes = {do_clear, do_spawn, do_cw, do_ccw, do_left, do_right, do_down, do_lock, do_elim, score_hit};

   task automatic zero_counts();
      n_any = 0; n_cw = 0; n_left = 0; n_down = 0; n_lock = 0; n_elim = 0;
   endtask

   // one tick edge; outputs are sampled on the following falling edge
   task automatic step_tick();
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      n_any  += $countones(strobes);
      n_cw   += int'(do_cw);
      n_left += int'(do_left);
      n_down += int'(do_down);
      n_lock += int'(do_lock);
      n_elim += int'(do_elim);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step_tick();
   endtask

   // k = {esc, cw, ccw, left, right, drop}, held for one clk with tick low
   task automatic press(input logic [5:0] k);
      @(negedge clk) {key_esc, key_cw, key_ccw, key_left, key_right, key_drop} = k;
      @(negedge clk) {key_esc, key_cw, key_ccw, key_left, key_right, key_drop} = 6'd0;
   endtask

   task automatic restart();
      @(negedge clk) rst = 1'b1;
      tick = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ticks(2);
      zero_counts();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (strobes !== 10'd0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0", strobes); end
      n_checks++; if (state_dbg !== ST_CLEAR) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
      n_checks++; if ({game_over, line_cnt} !== 3'd0) begin n_fail++; $display("FAIL reset_levels: got %b want 000", {game_over, line_cnt}); end
      rst = 1'b0;
      step_tick();
      n_checks++; if (strobes !== 10'b1000000000) begin n_fail++; $display("FAIL first_tick_clear: got %b want 1000000000", strobes); end
      step_tick();
      n_checks++; if (strobes !== 10'b0100000000) begin n_fail++; $display("FAIL second_tick_spawn: got %b want 0100000000", strobes); end
      n_checks++; if (state_dbg !== ST_CW || game_over !== 1'b0) begin n_fail++; $display("FAIL reach_cw: got state %0d go %b want 2 0", state_dbg, game_over); end
   endtask

   task automatic test_left();
      restart();
      press(6'b000100);
      ticks(3);
      n_checks++; if (strobes !== 10'b0000100000) begin n_fail++; $display("FAIL left_strobe: got %b want 0000100000", strobes); end
      n_checks++; if (state_dbg !== ST_RIGHT) begin n_fail++; $display("FAIL left_state: got %0d want 5", state_dbg); end
      @(negedge clk);
      n_checks++; if (do_left !== 1'b0) begin n_fail++; $display("FAIL left_one_clk: got %b want 0", do_left); end
      ticks(2);
      zero_counts();
      ticks(5);
      n_checks++; if (n_left !== 0) begin n_fail++; $display("FAIL left_flag_cleared: got %0d want 0", n_left); end
      left_ok = 1'b0;
      press(6'b000100);
      ticks(5);
      n_checks++; if (n_left !== 0) begin n_fail++; $display("FAIL left_blocked: got %0d want 0", n_left); end
      left_ok = 1'b1;
      ticks(5);
      n_checks++; if (n_left !== 0) begin n_fail++; $display("FAIL left_blocked_flag_cleared: got %0d want 0", n_left); end
   endtask

   task automatic test_gravity();
      restart();
      down_ok = 1'b1;
      ticks(29);
      n_checks++; if (n_down !== 0 || state_dbg !== ST_FALL) begin n_fail++; $display("FAIL grav_early: got downs %0d state %0d want 0 6", n_down, state_dbg); end
      step_tick();
      n_checks++; if (do_down !== 1'b1 || state_dbg !== ST_CW) begin n_fail++; $display("FAIL grav_fall1: got %b state %0d want 1 2", do_down, state_dbg); end
      zero_counts();
      ticks(30);
      n_checks++; if (n_down !== 1 || do_down !== 1'b1) begin n_fail++; $display("FAIL grav_fall2: got downs %0d last %b want 1 1", n_down, do_down); end
      down_ok = 1'b0;
      zero_counts();
      ticks(30);
      n_checks++; if (state_dbg !== ST_LOCK || n_down !== 0) begin n_fail++; $display("FAIL grav_to_lock: got state %0d downs %0d want 8 0", state_dbg, n_down); end
      step_tick();
      n_checks++; if (do_lock !== 1'b1 || state_dbg !== ST_ELIM) begin n_fail++; $display("FAIL grav_lock: got %b state %0d want 1 9", do_lock, state_dbg); end
      down_ok = 1'b1;
   endtask

   task automatic test_hard_drop();
      logic all_down;
      restart();
      down_ok = 1'b1;
      press(6'b000001);
      ticks(5);
      n_checks++; if (state_dbg !== ST_HDROP || n_down !== 0) begin n_fail++; $display("FAIL hdrop_entry: got state %0d downs %0d want 7 0", state_dbg, n_down); end
      zero_counts();
      all_down = 1'b1;
      for (int i = 0; i < 24; i++) begin
         step_tick();
         all_down &= do_down;
      end
      n_checks++; if (n_down !== 24 || all_down !== 1'b1) begin n_fail++; $display("FAIL hdrop_24: got %0d consecutive %b want 24 1", n_down, all_down); end
      step_tick();
      n_checks++; if (do_down !== 1'b0 || state_dbg !== ST_LOCK) begin n_fail++; $display("FAIL hdrop_limit: got %b state %0d want 0 8", do_down, state_dbg); end
      step_tick();
      n_checks++; if (do_lock !== 1'b1 || state_dbg !== ST_ELIM) begin n_fail++; $display("FAIL hdrop_lock: got %b state %0d want 1 9", do_lock, state_dbg); end
   endtask

   task automatic test_rows();
      zero_counts();
      row_full = 1'b1;
      ticks(3);
      row_full = 1'b0;
      n_checks++; if (n_elim !== 3 || state_dbg !== ST_ELIM) begin n_fail++; $display("FAIL elim3: got %0d state %0d want 3 9", n_elim, state_dbg); end
      step_tick();
      n_checks++; if (strobes !== 10'd0 || state_dbg !== ST_SCORE) begin n_fail++; $display("FAIL elim3_done: got %b state %0d want 0 10", strobes, state_dbg); end
      step_tick();
      n_checks++; if (score_hit !== 1'b1 || line_cnt !== 2'd2) begin n_fail++; $display("FAIL score3: got %b lines %0d want 1 2", score_hit, line_cnt); end
      step_tick();
      n_checks++; if (state_dbg !== ST_SPAWN) begin n_fail++; $display("FAIL check_to_spawn: got %0d want 1", state_dbg); end
      step_tick();
      down_ok = 1'b0;
      press(6'b000001);
      ticks(7);
      n_checks++; if (do_lock !== 1'b1) begin n_fail++; $display("FAIL blocked_drop_lock: got %b want 1", do_lock); end
      zero_counts();
      row_full = 1'b1;
      ticks(5);
      n_checks++; if (n_elim !== 4 || state_dbg !== ST_SCORE) begin n_fail++; $display("FAIL elim_sat: got %0d state %0d want 4 10", n_elim, state_dbg); end
      step_tick();
      row_full = 1'b0;
      n_checks++; if (score_hit !== 1'b1 || line_cnt !== 2'd3) begin n_fail++; $display("FAIL score4: got %b lines %0d want 1 3", score_hit, line_cnt); end
      @(negedge clk);
      n_checks++; if ({score_hit, line_cnt} !== 3'd0) begin n_fail++; $display("FAIL score_clears: got %b want 000", {score_hit, line_cnt}); end
      down_ok = 1'b1;
   endtask

   task automatic test_game_over();
      restart();
      down_ok = 1'b0;
      press(6'b000001);
      ticks(9);
      n_checks++; if (state_dbg !== ST_CHECK || score_hit !== 1'b0) begin n_fail++; $display("FAIL no_rows_no_score: got state %0d score %b want 11 0", state_dbg, score_hit); end
      spawn_blocked = 1'b1;
      step_tick();
      n_checks++; if (game_over !== 1'b1 || state_dbg !== ST_OVER) begin n_fail++; $display("FAIL over_entry: got %b state %0d want 1 12", game_over, state_dbg); end
      zero_counts();
      for (int i = 0; i < 20; i++) begin
         press(6'b010100);
         step_tick();
      end
      n_checks++; if (n_any !== 0 || game_over !== 1'b1 || state_dbg !== ST_OVER) begin n_fail++; $display("FAIL over_frozen: got strobes %0d go %b state %0d want 0 1 12", n_any, game_over, state_dbg); end
      spawn_blocked = 1'b0;
      down_ok = 1'b1;
      press(6'b100000);
      step_tick();
      n_checks++; if (state_dbg !== ST_CLEAR || strobes !== 10'd0) begin n_fail++; $display("FAIL esc_to_clear: got state %0d strobes %b want 0 0", state_dbg, strobes); end
      step_tick();
      n_checks++; if (do_clear !== 1'b1 || game_over !== 1'b0) begin n_fail++; $display("FAIL esc_clear: got %b go %b want 1 0", do_clear, game_over); end
      step_tick();
      n_checks++; if (do_spawn !== 1'b1 || state_dbg !== ST_CW) begin n_fail++; $display("FAIL esc_spawn: got %b state %0d want 1 2", do_spawn, state_dbg); end
      zero_counts();
      ticks(5);
      n_checks++; if (n_cw !== 0 || n_left !== 0) begin n_fail++; $display("FAIL over_flags_cleared: got cw %0d left %0d want 0 0", n_cw, n_left); end
   endtask

   task automatic test_esc_priority();
      restart();
      press(6'b000100);
      ticks(2);
      press(6'b100000);
      step_tick();
      n_checks++; if (state_dbg !== ST_CLEAR || strobes !== 10'd0) begin n_fail++; $display("FAIL esc_priority: got state %0d strobes %b want 0 0", state_dbg, strobes); end
   endtask

   task automatic test_reset_abort();
      restart();
      down_ok = 1'b1;
      press(6'b000001);
      ticks(8);
      n_checks++; if (do_down !== 1'b1 || state_dbg !== ST_HDROP) begin n_fail++; $display("FAIL abort_setup: got %b state %0d want 1 7", do_down, state_dbg); end
      @(negedge clk) begin rst = 1'b1; tick = 1'b1; end
      @(negedge clk);
      n_checks++; if (strobes !== 10'd0 || state_dbg !== ST_CLEAR) begin n_fail++; $display("FAIL abort_reset: got %b state %0d want 0 0", strobes, state_dbg); end
      rst = 1'b0;
      tick = 1'b0;
      ticks(7);
      n_checks++; if (state_dbg !== ST_CW) begin n_fail++; $display("FAIL abort_drop_cleared: got %0d want 2", state_dbg); end
   endtask

   initial begin
      zero_counts();
      test_reset();
      test_left();
      test_gravity();
      test_hard_drop();
      test_rows();
      test_game_over();
      test_esc_priority();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
